// File: rtl/counter_bus_pkg.sv
// Shared definitions for the counter bus arbiter.
//   CB_DW     : default width of the shared counter data bus
//   RD_CNT_W  : width of the read-wait down-counter (holds RD_WAIT-1, RD_WAIT <= 15)
//   cb_state_e: transaction FSM state encoding
package counter_bus_pkg;

    localparam int CB_DW    = 34;
    localparam int RD_CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        W_SETUP  = 3'd1,
        W_STROBE = 3'd2,
        W_HOLD   = 3'd3,
        R_OE     = 3'd4,
        R_SAMPLE = 3'd5,
        R_TURN   = 3'd6,
        DONE     = 3'd7
    } cb_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter.
//   clk_i  : clock (rising edge)
//   rst_n  : synchronous active-low reset
//   req    : request vector, bit n = requester n
//   enable : arbitration allowed this cycle (grant forced to 0 otherwise)
//   grant  : one-hot combinational grant, valid in the cycle req is sampled
//   last   : pointer state, index of the requester granted most recently
module rr_arbiter2 (
    input  logic       clk_i,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       enable,
    output logic [1:0] grant,
    output logic       last
);

    logic last_reg;
    logic last_next;

    always_comb begin
        grant     = 2'b00;
        last_next = last_reg;
        if (enable) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                // On a tie, favour whoever was not served last.
                2'b11:   grant = last_reg ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
        // Pointer only moves when a grant is actually issued.
        if (grant[0]) begin
            last_next = 1'b0;
        end else if (grant[1]) begin
            last_next = 1'b1;
        end
    end

    // Out of reset requester 1 counts as last served so requester 0 wins the first tie.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            last_reg <= 1'b1;
        end else begin
            last_reg <= last_next;
        end
    end

    assign last = last_reg;

endmodule

// File: rtl/counter_bus_arbiter.sv
// Arbitrates two requesters onto a shared external counter bus and sequences
// load (write) and read cycles with the required strobe timing.
//   clk_i              : clock (rising edge)
//   rst_n              : synchronous active-low reset
//   req_i[1:0]         : per-requester request, held until its ack
//   wr_i[1:0]          : per-requester op, 1 = load counter, 0 = read counter
//   wdata0_i/wdata1_i  : per-requester load value
//   ack_o[1:0]         : one-cycle completion pulse to the served requester
//   rdata_o            : last value sampled from the counter
//   busy_o             : transaction in progress
//   ctr_oe_n_o         : counter output enable, active-low (registered)
//   ctr_we_n_o         : counter load strobe, active-low (registered)
//   ctr_d_o/ctr_d_oe_o : data toward the counter and its drive enable
//   ctr_d_i            : data returned by the counter
module counter_bus_arbiter
    import counter_bus_pkg::*;
#(
    parameter int DW      = CB_DW,
    parameter int RD_WAIT = 2
) (
    input  logic          clk_i,
    input  logic          rst_n,
    input  logic [1:0]    req_i,
    input  logic [1:0]    wr_i,
    input  logic [DW-1:0] wdata0_i,
    input  logic [DW-1:0] wdata1_i,
    output logic [1:0]    ack_o,
    output logic [DW-1:0] rdata_o,
    output logic          busy_o,
    output logic          ctr_oe_n_o,
    output logic          ctr_we_n_o,
    output logic [DW-1:0] ctr_d_o,
    output logic          ctr_d_oe_o,
    input  logic [DW-1:0] ctr_d_i
);

    cb_state_e             state_reg, state_next;
    logic [1:0]            gnt_reg, gnt_next;
    logic                  wr_reg, wr_next;
    logic [DW-1:0]         wdata_reg, wdata_next;
    logic [RD_CNT_W-1:0]   cnt_reg, cnt_next;
    logic [DW-1:0]         rdata_reg;
    logic                  oe_n_reg, oe_n_next;
    logic                  we_n_reg, we_n_next;
    logic                  d_oe_reg, d_oe_next;
    logic [1:0]            ack_reg, ack_next;

    logic [1:0]            arb_grant;
    logic                  arb_en;
    logic                  rr_last;

    assign arb_en = (state_reg == IDLE);

    rr_arbiter2 u_rr_arbiter2 (
        .clk_i  (clk_i),
        .rst_n  (rst_n),
        .req    (req_i),
        .enable (arb_en),
        .grant  (arb_grant),
        .last   (rr_last)
    );

    // Next-state logic. Request, op and data are latched at grant so later
    // changes on the requester side cannot disturb the transaction.
    always_comb begin
        state_next = state_reg;
        gnt_next   = gnt_reg;
        wr_next    = wr_reg;
        wdata_next = wdata_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (arb_grant != 2'b00) begin
                    gnt_next = arb_grant;
                    wr_next  = arb_grant[1] ? wr_i[1] : wr_i[0];
                    if (wr_next) begin
                        wdata_next = arb_grant[1] ? wdata1_i : wdata0_i;
                        state_next = W_SETUP;
                    end else begin
                        cnt_next   = RD_CNT_W'(RD_WAIT - 1);
                        state_next = R_OE;
                    end
                end
            end
            W_SETUP:  state_next = W_STROBE;
            W_STROBE: state_next = W_HOLD;
            W_HOLD:   state_next = DONE;
            R_OE: begin
                // Counter runs RD_WAIT-1 .. 0, giving RD_WAIT cycles of OE before sampling.
                if (cnt_reg == '0) begin
                    state_next = R_SAMPLE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            R_SAMPLE: state_next = R_TURN;
            R_TURN:   state_next = DONE;
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Pad strobes are decoded from the next state and registered, so each
    // strobe lines up exactly with its state and comes straight from a flop.
    always_comb begin
        oe_n_next = 1'b1;
        we_n_next = 1'b1;
        d_oe_next = 1'b0;
        ack_next  = 2'b00;
        case (state_next)
            W_SETUP:  d_oe_next = 1'b1;
            W_STROBE: begin
                d_oe_next = 1'b1;
                we_n_next = 1'b0;
            end
            W_HOLD:   d_oe_next = 1'b1;
            R_OE:     oe_n_next = 1'b0;
            R_SAMPLE: oe_n_next = 1'b0;
            DONE:     ack_next  = gnt_next;
            default: begin
                oe_n_next = 1'b1;
                we_n_next = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            gnt_reg   <= 2'b00;
            wr_reg    <= 1'b0;
            wdata_reg <= '0;
            cnt_reg   <= '0;
            rdata_reg <= '0;
            oe_n_reg  <= 1'b1;
            we_n_reg  <= 1'b1;
            d_oe_reg  <= 1'b0;
            ack_reg   <= 2'b00;
        end else begin
            state_reg <= state_next;
            gnt_reg   <= gnt_next;
            wr_reg    <= wr_next;
            wdata_reg <= wdata_next;
            cnt_reg   <= cnt_next;
            oe_n_reg  <= oe_n_next;
            we_n_reg  <= we_n_next;
            d_oe_reg  <= d_oe_next;
            ack_reg   <= ack_next;
            if (state_reg == R_SAMPLE) begin
                rdata_reg <= ctr_d_i;
            end
        end
    end

    assign ack_o      = ack_reg;
    assign rdata_o    = rdata_reg;
    assign busy_o     = (state_reg != IDLE);
    assign ctr_oe_n_o = oe_n_reg;
    assign ctr_we_n_o = we_n_reg;
    assign ctr_d_o    = wdata_reg;
    assign ctr_d_oe_o = d_oe_reg;

    // The arbiter pointer and the latched grant move together, so while a
    // transaction is active they must agree.
    a_ptr_matches_grant: assert property (@(posedge clk_i) disable iff (!rst_n)
        (state_reg != IDLE) |-> (rr_last == gnt_reg[1]));

    // Never drive the bus while the counter is enabled onto it.
    a_no_bus_fight: assert property (@(posedge clk_i) disable iff (!rst_n)
        !(ctr_d_oe_o && !ctr_oe_n_o));

endmodule

// File: tb/tb_counter_bus_arbiter.sv
module tb_counter_bus_arbiter;

    localparam int DW = 34;

    logic          clk_i;
    logic          rst_n;
    logic [1:0]    req_i;
    logic [1:0]    wr_i;
    logic [DW-1:0] wdata0_i;
    logic [DW-1:0] wdata1_i;
    logic [1:0]    ack_o;
    logic [DW-1:0] rdata_o;
    logic          busy_o;
    logic          ctr_oe_n_o;
    logic          ctr_we_n_o;
    logic [DW-1:0] ctr_d_o;
    logic          ctr_d_oe_o;
    logic [DW-1:0] ctr_d_i;

    counter_bus_arbiter #(.DW(DW), .RD_WAIT(2)) dut (
        .clk_i      (clk_i),
        .rst_n      (rst_n),
        .req_i      (req_i),
        .wr_i       (wr_i),
        .wdata0_i   (wdata0_i),
        .wdata1_i   (wdata1_i),
        .ack_o      (ack_o),
        .rdata_o    (rdata_o),
        .busy_o     (busy_o),
        .ctr_oe_n_o (ctr_oe_n_o),
        .ctr_we_n_o (ctr_we_n_o),
        .ctr_d_o    (ctr_d_o),
        .ctr_d_oe_o (ctr_d_oe_o),
        .ctr_d_i    (ctr_d_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;
    int viol_cnt = 0;

    // Per-cycle history of one transaction; index k = cycles after req was seen.
    logic [15:0]   we_h, oe_h, doe_h, busy_h;
    logic [1:0]    ack_h   [16];
    logic [DW-1:0] rdata_h [16];
    logic [DW-1:0] d_h     [16];

    logic [1:0]    rr_order [4];
    int            rr_n;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Bus invariants, sampled away from the active edge.
    always @(negedge clk_i) begin
        if (ctr_d_oe_o === 1'b1 && ctr_oe_n_o === 1'b0) viol_cnt++;
        if (ack_o === 2'b11) viol_cnt++;
    end

    // Drive one request from a negedge and record ncyc cycles of outputs.
    // A requester drops its req on seeing its ack. With mutate set, req, op
    // and data are all changed right after the grant.
    task automatic txn(input logic [1:0] r, input logic [1:0] w, input int ncyc, input bit mutate);
        req_i  = r;
        wr_i   = w;
        we_h   = '1;
        oe_h   = '1;
        doe_h  = '0;
        busy_h = '0;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk_i);
            we_h[k]    = ctr_we_n_o;
            oe_h[k]    = ctr_oe_n_o;
            doe_h[k]   = ctr_d_oe_o;
            busy_h[k]  = busy_o;
            ack_h[k]   = ack_o;
            rdata_h[k] = rdata_o;
            d_h[k]     = ctr_d_o;
            if (ack_o != 2'b00) req_i = req_i & ~ack_o;
            if (mutate && k == 1) begin
                req_i    = 2'b00;
                wr_i     = ~wr_i;
                wdata0_i = ~wdata0_i;
                wdata1_i = ~wdata1_i;
            end
        end
        $display("txn req=%b wr=%b: we_n=%b oe_n=%b d_oe=%b ack@4=%b ack@5=%b rdata@%0d=0x%0h",
                 r, w, we_h[6:1], oe_h[6:1], doe_h[6:1], ack_h[4], ack_h[5], ncyc, rdata_h[ncyc]);
    endtask

    initial begin
        rst_n    = 1'b0;
        req_i    = 2'b00;
        wr_i     = 2'b00;
        wdata0_i = '0;
        wdata1_i = '0;
        ctr_d_i  = '0;

        // Reset values
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_ack",  ack_o,      2'b00);
        check("rst_rdata", rdata_o,   0);
        check("rst_busy", busy_o,     0);
        check("rst_oe_n", ctr_oe_n_o, 1);
        check("rst_we_n", ctr_we_n_o, 1);
        check("rst_d",    ctr_d_o,    0);
        check("rst_d_oe", ctr_d_oe_o, 0);
        rst_n = 1'b1;

        // Requester 0 write
        wdata0_i = 34'h2_0000_0001;
        txn(2'b01, 2'b01, 5, 1'b0);
        check("wr_we_n_1to5", we_h[5:1],  5'b11101);
        check("wr_d_oe_1to5", doe_h[5:1], 5'b00111);
        for (int k = 1; k <= 3; k++) check($sformatf("wr_d_c%0d", k), d_h[k], 34'h2_0000_0001);
        check("wr_ack_c3", ack_h[3], 2'b00);
        check("wr_ack_c4", ack_h[4], 2'b01);
        check("wr_ack_c5", ack_h[5], 2'b00);
        check("wr_busy_1to5", busy_h[5:1], 5'b01111);

        // Requester 1 read
        ctr_d_i = 34'h0_DEAD_BEEF;
        txn(2'b10, 2'b00, 6, 1'b0);
        check("rd_oe_n_1to6", oe_h[6:1],  6'b111000);
        check("rd_d_oe_1to6", doe_h[6:1], 6'b000000);
        check("rd_rdata_c3", rdata_h[3], 0);
        check("rd_rdata_c4", rdata_h[4], 34'h0_DEAD_BEEF);
        check("rd_ack_c4", ack_h[4], 2'b00);
        check("rd_ack_c5", ack_h[5], 2'b10);
        check("rd_busy_5to6", busy_h[6:5], 2'b01);
        ctr_d_i = 34'h1_2345_6789;

        // Requester 0 write, then req/op/data change right after grant
        wdata0_i = 34'h3_0000_00AA;
        txn(2'b01, 2'b01, 5, 1'b1);
        check("mut_we_n_1to5", we_h[5:1], 5'b11101);
        check("mut_d_c2", d_h[2], 34'h3_0000_00AA);
        check("mut_d_c3", d_h[3], 34'h3_0000_00AA);
        check("mut_ack_c4", ack_h[4], 2'b01);
        check("mut_rdata_kept", rdata_h[5], 34'h0_DEAD_BEEF);

        // Round robin with both requesting reads continuously after reset
        rst_n = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_n = 1'b1;
        req_i = 2'b11;
        wr_i  = 2'b00;
        rr_n  = 0;
        for (int i = 0; i < 40 && rr_n < 4; i++) begin
            @(negedge clk_i);
            if (ack_o != 2'b00) begin
                rr_order[rr_n] = ack_o;
                rr_n++;
            end
        end
        req_i = 2'b00;
        $display("txn rr: %0d acks, order %b %b %b %b", rr_n, rr_order[0], rr_order[1], rr_order[2], rr_order[3]);
        check("rr_count", rr_n, 4);
        check("rr_ack0", rr_order[0], 2'b01);
        check("rr_ack1", rr_order[1], 2'b10);
        check("rr_ack2", rr_order[2], 2'b01);
        check("rr_ack3", rr_order[3], 2'b10);

        // Reset asserted while in W_STROBE
        @(negedge clk_i);
        wdata0_i = 34'h0_0000_0155;
        req_i    = 2'b01;
        wr_i     = 2'b01;
        @(negedge clk_i);
        @(negedge clk_i);
        check("mr_we_n_strobe", ctr_we_n_o, 0);
        rst_n = 1'b0;
        @(negedge clk_i);
        check("mr_we_n", ctr_we_n_o, 1);
        check("mr_d_oe", ctr_d_oe_o, 0);
        check("mr_busy", busy_o,     0);
        check("mr_ack",  ack_o,      2'b00);
        req_i = 2'b00;
        @(negedge clk_i);
        check("mr_ack_after", ack_o, 2'b00);
        rst_n = 1'b1;
        $display("txn reset during W_STROBE: we_n=%b d_oe=%b busy=%b", ctr_we_n_o, ctr_d_oe_o, busy_o);
        repeat (3) @(negedge clk_i);

        check("bus_invariants", viol_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
